// File: rtl/seq_1101_pkg.sv
// seq_1101_pkg: state encoding and sync-header constants shared by the 1101 frame transmitter.
package seq_1101_pkg;
  typedef enum logic [2:0] {S_IDLE, S_SYNC, S_DATA, S_PAR, S_DONE} state_e;
  localparam logic [3:0] SYNC_DEFAULT = 4'b1101;
  localparam int SYNC_LEN = 4;
endpackage

// File: rtl/piso_shift_reg.sv
// piso_shift_reg: loadable MSB-first parallel-in/serial-out register.
module piso_shift_reg #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic             shift,
  input  logic [WIDTH-1:0] din,
  output logic             sout
);
  logic [WIDTH-1:0] sr_q, sr_d;
  always_comb sr_d = load ? din : shift ? sr_q << 1 : sr_q;
  always_ff @(posedge clk or posedge reset)
    if (reset) sr_q <= '0;
    else sr_q <= sr_d;
  assign sout = sr_q[WIDTH-1];
endmodule

// File: rtl/seq_1101_tx.sv
// seq_1101_tx: serial frame transmitter (4-bit sync header + MSB-first payload); define
// SEQ_TX_PARITY_EN to append an even-parity bit after the payload.
module seq_1101_tx
  import seq_1101_pkg::*;
#(
  parameter int         DATA_W = 8,
  parameter logic [3:0] SYNC   = SYNC_DEFAULT
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [DATA_W-1:0] data,
  output logic              busy,
  output logic              out,
  output logic              out_valid,
  output logic              done
);
  localparam int IW = 5;
`ifdef SEQ_TX_PARITY_EN
  localparam state_e AFTER_DATA = S_PAR;
`else
  localparam state_e AFTER_DATA = S_DONE;
`endif
  state_e state_q, state_d;
  logic [IW-1:0] idx_q, idx_d;
  logic busy_q, busy_d, out_q, out_d, valid_q, valid_d, done_q, done_d;
  logic accept, shift, sout;
`ifdef SEQ_TX_PARITY_EN
  logic par_q, par_d;
`endif
  // Outputs are computed from the next state so every output port is a flop.
  always_comb begin
    accept  = start && (state_q == S_IDLE || state_q == S_DONE);
    state_d = state_q;
    idx_d   = idx_q;
    if (accept) begin
      state_d = S_SYNC;
      idx_d   = IW'(SYNC_LEN - 1);
    end else if (state_q == S_DONE) begin
      state_d = S_IDLE;
    end else if (state_q == S_SYNC) begin
      state_d = idx_q == '0 ? S_DATA : S_SYNC;
      idx_d   = idx_q == '0 ? IW'(DATA_W - 1) : idx_q - IW'(1);
    end else if (state_q == S_DATA) begin
      state_d = idx_q == '0 ? AFTER_DATA : S_DATA;
      idx_d   = idx_q == '0 ? '0 : idx_q - IW'(1);
    end else if (state_q == S_PAR) begin
      state_d = S_DONE;
    end
    shift   = state_d == S_DATA;
    out_d   = state_d == S_SYNC ? SYNC[idx_d[1:0]] : state_d == S_DATA ? sout : 1'b0;
`ifdef SEQ_TX_PARITY_EN
    par_d   = accept ? ^data : par_q;
    if (state_d == S_PAR) out_d = par_q;
`endif
    valid_d = state_d inside {S_SYNC, S_DATA, S_PAR};
    busy_d  = valid_d;
    done_d  = state_d == S_DONE;
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      busy_q  <= 1'b0;
      out_q   <= 1'b0;
      valid_q <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      busy_q  <= busy_d;
      out_q   <= out_d;
      valid_q <= valid_d;
      done_q  <= done_d;
    end
`ifdef SEQ_TX_PARITY_EN
  always_ff @(posedge clk or posedge reset)
    if (reset) par_q <= 1'b0;
    else par_q <= par_d;
`endif
  piso_shift_reg #(.WIDTH(DATA_W)) u_piso (
    .clk   (clk),
    .reset (reset),
    .load  (accept),
    .shift (shift),
    .din   (data),
    .sout  (sout)
  );
  assign busy      = busy_q;
  assign out       = out_q;
  assign out_valid = valid_q;
  assign done      = done_q;
endmodule

// File: tb/tb_seq_1101_tx.sv
// tb_seq_1101_tx: directed self-checking bench for seq_1101_tx (honours SEQ_TX_PARITY_EN).
module tb_seq_1101_tx;
`ifdef SEQ_TX_PARITY_EN
  localparam int N = 13;
`else
  localparam int N = 12;
`endif
  logic clk = 1'b0, reset = 1'b1, start = 1'b0;
  logic [7:0] data = '0;
  logic busy, out, out_valid, done;
  int total = 0, bad = 0;
  always #5 clk = ~clk;
  seq_1101_tx dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .data      (data),
    .busy      (busy),
    .out       (out),
    .out_valid (out_valid),
    .done      (done)
  );
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  function automatic logic exp_bit(input logic [7:0] d, input int i);
    logic [3:0] s;
    s = 4'b1101;
    if (i < 4) return s[3-i];
    if (i < 12) return d[11-i];
    return ^d;
  endfunction
  task automatic check_idle(input string tag);
    chk({tag, "_valid"}, out_valid, 0);
    chk({tag, "_out"}, out, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
  endtask
  task automatic run_frame(input logic [7:0] d, input int inj);
    start = 1'b1;
    data  = d;
    tick();
    start = 1'b0;
    data  = 8'h3C;
    for (int i = 0; i < N; i++) begin
      chk($sformatf("valid%0d", i), out_valid, 1);
      chk($sformatf("bit%0d", i), out, exp_bit(d, i));
      chk($sformatf("busy%0d", i), busy, 1);
      chk($sformatf("nodone%0d", i), done, 0);
      if (i == inj) begin
        start = 1'b1;
        data  = 8'hFF;
      end
      tick();
      start = 1'b0;
    end
    chk("done_pulse", done, 1);
    chk("done_valid", out_valid, 0);
    chk("done_out", out, 0);
    chk("done_busy", busy, 0);
    tick();
    check_idle("post_done");
    tick();
    check_idle("post_done2");
  endtask
  initial begin
    logic [3:0] win;
    int dets;
    #1;
    check_idle("in_reset");
    #9;
    reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      check_idle("idle");
    end
    run_frame(8'hA5, -1);
    run_frame(8'hA5, 2);
    // continuous start: two frames back to back, then release start at the second done
    start = 1'b1;
    data  = 8'h0D;
    tick();
    win  = '0;
    dets = 0;
    for (int f = 0; f < 2; f++) begin
      for (int i = 0; i < N; i++) begin
        chk($sformatf("b2b_valid%0d_%0d", f, i), out_valid, 1);
        chk($sformatf("b2b_bit%0d_%0d", f, i), out, exp_bit(8'h0D, i));
        win = {win[2:0], out};
        if (win == 4'b1101) dets++;
        tick();
      end
      chk($sformatf("b2b_gap%0d", f), out_valid, 0);
      chk($sformatf("b2b_done%0d", f), done, 1);
      if (f == 1) start = 1'b0;
      tick();
    end
    chk("b2b_dets", dets, 4);
    check_idle("b2b_end");
    // reset during the 6th frame bit
    start = 1'b1;
    data  = 8'hA5;
    tick();
    start = 1'b0;
    for (int i = 0; i < 5; i++) tick();
    chk("pre_rst_busy", busy, 1);
    chk("pre_rst_valid", out_valid, 1);
    #2;
    reset = 1'b1;
    #1;
    check_idle("async_rst");
    tick();
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check_idle("after_rst");
    end
    run_frame(8'hA5, -1);
    run_frame(8'h5A, -1);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/seq_1101_tx.md
SEQ_1101_TX -- requirements
Module: seq_1101_tx

Interface
REQ-001 Parameter DATA_W, default 8, payload bits per frame (legal range 1..32).
REQ-002 Parameter SYNC, default 4'b1101, 4-bit sync header sent MSB-first ahead of every payload.
REQ-003 clk  input  1  system clock; all state updates on rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 start  input  1  frame request; sampled on the rising edge of clk.
REQ-006 data  input  DATA_W  payload; captured only on the edge that accepts start.
REQ-007 busy  output  1  frame in progress; start is not accepted while busy is high.
REQ-008 out  output  1  serial bit stream, one bit per clk.
REQ-009 out_valid  output  1  out carries a frame bit this cycle.
REQ-010 done  output  1  one-cycle pulse after the last frame bit.

Function
REQ-011 States SHALL be IDLE, SYNC, DATA, PAR (present only with the Configuration macro) and DONE.
REQ-012 In IDLE, start=1 at a rising edge SHALL capture data, enter SYNC, set bit index=3 and raise busy in the next cycle.
REQ-013 SYNC SHALL drive out=SYNC[idx] for 4 cycles, idx 3 down to 0, then enter DATA with idx=DATA_W-1.
REQ-014 DATA SHALL drive out=captured data[idx], MSB-first, for DATA_W cycles.
REQ-015 After DATA (or PAR), the FSM SHALL enter DONE for exactly one cycle with done=1, busy=0, out_valid=0 and out=0.
REQ-016 DONE SHALL behave as IDLE for start acceptance, so back-to-back frames have a 1-cycle gap.
REQ-017 out_valid and busy SHALL be 1 in SYNC, DATA and PAR, and 0 in IDLE and DONE.
REQ-018 out SHALL be 0 whenever out_valid=0.
REQ-019 Frame length SHALL be 4+DATA_W cycles, or 5+DATA_W cycles with parity.
REQ-020 start asserted while busy=1 SHALL be ignored, with no queuing and no corruption of the frame in flight.
REQ-021 Changes on data after acceptance SHALL NOT affect the frame in flight.
REQ-022 All outputs SHALL be registered, with no combinational path from inputs to outputs.

Reset
REQ-023 reset=1 SHALL, immediately and asynchronously, force state=IDLE, busy=0, out=0, out_valid=0, done=0, and clear the shift register and index.
REQ-024 Reset mid-frame SHALL abort the frame with no done pulse.
REQ-025 The first start accepted after reset deasserts SHALL send a complete frame.

Configuration
REQ-026 With macro SEQ_TX_PARITY_EN defined, PAR SHALL follow DATA for one cycle, driving out=XOR of captured data (even parity) with out_valid=1.
REQ-027 Without SEQ_TX_PARITY_EN, PAR SHALL not exist, DATA SHALL go directly to DONE, and no parity logic SHALL be synthesized.

Structure
REQ-028 The shared package seq_1101_pkg SHALL hold the state encoding (IDLE, SYNC, DATA, PAR, DONE), the default SYNC constant 4'b1101, and the sync length constant 4.
REQ-029 The loadable MSB-first parallel-in/serial-out register SHALL be the sub-module piso_shift_reg (parameter WIDTH; ports clk, reset, load, shift, din, sout); the FSM and index counter stay in seq_1101_tx.

Verification
REQ-030 reset=1 for 10 ns then released, start=0 -> out=0, out_valid=0, busy=0, done=0 throughout.
REQ-031 start=1 for one cycle with data=8'hA5, no parity -> out stream 1,1,0,1,1,0,1,0,0,1,0,1 on 12 consecutive out_valid cycles, then done=1 for one cycle.
REQ-032 Same frame with SEQ_TX_PARITY_EN defined -> 13 bits, the last being 0 (popcount of 8'hA5 is 4).
REQ-033 Second start pulse with data=8'hFF three cycles into a frame -> ignored; the current frame completes unchanged and no second frame is sent.
REQ-034 start held high continuously with data=8'h0D -> consecutive frames separated by exactly one out_valid=0 cycle; the stream fed to the overlapping 1101 detector yields out=1 at every sync and at payload-bit overlaps.
REQ-035 reset pulsed during the 6th frame bit -> out and busy drop to 0 asynchronously with no done pulse; the next start sends a full 12-bit frame.
